// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//
// Front end for the graphics controller.  Turns the raw board buttons into
// the clean signals the display top level consumes:
//   * every button is passed through a 2-FF synchroniser and a debouncer
//   * newPiece is the debounced level of btn_piece (the top level does its
//     own edge detection on it)
//   * controls[1:0] are single-cycle move pulses with hold-to-repeat: one
//     pulse on press, another DAS_DELAY cycles later, then one every
//     ARR_PERIOD cycles while the button stays held
//   * holding left and right together suppresses all movement
//
// Ports:
//   clk           in   system clock
//   rst           in   synchronous reset, active-high
//   btn_piece     in   raw asynchronous new-piece button
//   btn_controls  in   raw asynchronous move buttons (bit 0 left, bit 1 right)
//   newPiece      out  debounced level of btn_piece
//   controls      out  registered move pulses, one cycle wide per event
// -----------------------------------------------------------------------------
module input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DAS_DELAY       = 8333333,
   parameter int ARR_PERIOD      = 2500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_piece,
   input  logic [1:0] btn_controls,
   output logic       newPiece,
   output logic [1:0] controls
);

   // Debounce counter only ever holds 0 .. DEBOUNCE_CYCLES-1.
   localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   // One repeat timer covers both the DAS wait and the ARR period.
   localparam int TMR_MAX = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   localparam logic [CNT_W-1:0] DB_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DAS_TERM = TMR_W'(DAS_DELAY - 1);
   localparam logic [TMR_W-1:0] ARR_TERM = TMR_W'(ARR_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } state_t;

   // Channel 0 = piece, 1 = left, 2 = right.
   logic [2:0] raw;
   assign raw = {btn_controls, btn_piece};

   logic [2:0]            sync1_q, sync1_d;
   logic [2:0]            sync2_q, sync2_d;
   logic [2:0]            db_q, db_d;
   logic [2:0][CNT_W-1:0] db_cnt_q, db_cnt_d;

   state_t                state_q [2];
   state_t                state_d [2];
   logic [1:0][TMR_W-1:0] tmr_q, tmr_d;
   logic [1:0]            ctl_q, ctl_d;

   logic                  lockout;

   // ---------------------------------------------------------------------
   // Synchroniser and debouncer
   // ---------------------------------------------------------------------
   always_comb begin
      sync1_d  = raw;
      sync2_d  = sync1_q;
      db_d     = db_q;
      db_cnt_d = '0;
      for (int i = 0; i < 3; i++) begin
         // Counter runs only while the synchronised input disagrees with the
         // debounced state; any agreement (a bounce back) clears it.
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DB_TERM) begin
               db_d[i]     = sync2_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Repeat FSMs (one per direction)
   // ---------------------------------------------------------------------
   assign lockout = db_q[1] & db_q[2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_d[i] = state_q[i];
         tmr_d[i]   = tmr_q[i];
         ctl_d[i]   = 1'b0;
         if (lockout) begin
            // Opposing directions held: park both FSMs so whichever button
            // remains after the other is released starts over as a new press.
            state_d[i] = IDLE;
            tmr_d[i]   = '0;
         end else begin
            unique case (state_q[i])
               IDLE: begin
                  if (db_q[i+1]) begin
                     ctl_d[i]   = 1'b1;
                     tmr_d[i]   = '0;
                     state_d[i] = DELAY;
                  end
               end
               DELAY: begin
                  if (!db_q[i+1]) begin
                     state_d[i] = IDLE;
                     tmr_d[i]   = '0;
                  end else if (tmr_q[i] == DAS_TERM) begin
                     ctl_d[i]   = 1'b1;
                     tmr_d[i]   = '0;
                     state_d[i] = REPEAT;
                  end else begin
                     tmr_d[i] = tmr_q[i] + TMR_W'(1);
                  end
               end
               REPEAT: begin
                  if (!db_q[i+1]) begin
                     state_d[i] = IDLE;
                     tmr_d[i]   = '0;
                  end else if (tmr_q[i] == ARR_TERM) begin
                     ctl_d[i] = 1'b1;
                     tmr_d[i] = '0;
                  end else begin
                     tmr_d[i] = tmr_q[i] + TMR_W'(1);
                  end
               end
               default: begin
                  state_d[i] = IDLE;
                  tmr_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         db_q       <= '0;
         db_cnt_q   <= '0;
         state_q[0] <= IDLE;
         state_q[1] <= IDLE;
         tmr_q      <= '0;
         ctl_q      <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         db_q       <= db_d;
         db_cnt_q   <= db_cnt_d;
         state_q[0] <= state_d[0];
         state_q[1] <= state_d[1];
         tmr_q      <= tmr_d;
         ctl_q      <= ctl_d;
      end
   end

   assign newPiece = db_q[0];
   assign controls = ctl_q;

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
//
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, DAS_DELAY=10,
// ARR_PERIOD=3.  "Cycle n" of a scenario is the interval after the n-th
// rising edge counted from the moment the scenario's inputs are applied;
// outputs are sampled 1 time unit after each edge and compared as
// {newPiece, controls} against hand-derived values.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

   logic       clk;
   logic       rst;
   logic       btn_piece;
   logic [1:0] btn_controls;
   logic       newPiece;
   logic [1:0] controls;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .DAS_DELAY      (10),
      .ARR_PERIOD     (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_piece   (btn_piece),
      .btn_controls(btn_controls),
      .newPiece    (newPiece),
      .controls    (controls)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [2:0] exp);
      logic [2:0] obs;
      obs = {newPiece, controls};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed={np,ctl}=%b required=%b", tag, cyc, obs, exp);
      end
   endtask

   function automatic bit has(input int q[$], input int v);
      foreach (q[k]) if (q[k] == v) return 1'b1;
      return 1'b0;
   endfunction

   // Reset with buttons released, then leave the bench at cycle 0 of a
   // fresh scenario (rst already low, inputs may be set by the caller).
   task automatic apply_reset();
      rst          = 1'b1;
      btn_piece    = 1'b0;
      btn_controls = 2'b00;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      int left_p[$];
      int right_p[$];
      logic [1:0] ectl;

      // ---- Reset and idle: everything held during reset ----
      rst          = 1'b1;
      btn_piece    = 1'b1;
      btn_controls = 2'b11;
      for (int k = 0; k < 3; k++) begin
         step();
         check("reset_hold", 3'b000);
      end
      rst = 1'b0;
      cyc = 0;
      for (int k = 1; k <= 20; k++) begin
         step();
         check("reset_idle", {(cyc >= 6), 2'b00});
      end

      // ---- Single press then release of left ----
      apply_reset();
      btn_controls = 2'b01;
      left_p = '{7, 17, 20, 23, 26, 29, 32, 35, 38, 41, 44};
      for (int k = 1; k <= 60; k++) begin
         step();
         check("single_press", {1'b0, 1'b0, has(left_p, cyc)});
         if (cyc == 40) btn_controls = 2'b00;
      end

      // ---- Bounce rejection on btn_piece ----
      apply_reset();
      btn_piece = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         step();
         check("bounce", {(cyc >= 46), 2'b00});
         if (cyc < 30)      btn_piece = ((cyc / 2) % 2) == 0;
         else if (cyc < 40) btn_piece = 1'b0;
         else               btn_piece = 1'b1;
      end

      // ---- Short tap on right: one pulse only ----
      apply_reset();
      btn_controls = 2'b10;
      for (int k = 1; k <= 30; k++) begin
         step();
         check("short_tap", {1'b0, (cyc == 7), 1'b0});
         if (cyc == 7) btn_controls = 2'b00;
      end

      // ---- Opposing-direction lockout ----
      apply_reset();
      btn_controls = 2'b01;
      left_p  = '{7, 17};
      right_p = '{37, 47, 50, 53, 56, 59};
      for (int k = 1; k <= 60; k++) begin
         step();
         ectl = {has(right_p, cyc), has(left_p, cyc)};
         check("lockout", {1'b0, ectl});
         if (cyc == 12) btn_controls = 2'b11;
         if (cyc == 30) btn_controls = 2'b10;
      end

      // ---- Reset asserted mid-hold restarts everything ----
      apply_reset();
      btn_controls = 2'b01;
      left_p = '{7, 17, 20, 28, 38, 41, 44};
      for (int k = 1; k <= 45; k++) begin
         step();
         if (cyc == 21) begin
            check("mid_reset_clear", 3'b000);
            rst = 1'b0;
         end else begin
            check("mid_reset_hold", {1'b0, 1'b0, has(left_p, cyc)});
         end
         if (cyc == 20) rst = 1'b1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
